// File: rtl/dna_reader.sv
// Reads the DNA_PORT serial number MSB-first over a divided dna_clk; result is valid 2*CLK_HALF*DNA_WIDTH cycles after start.
// No backpressure: start is a single-cycle request that is dropped while a read is in progress.
module dna_reader #(
  parameter int DNA_WIDTH  = 57,
  parameter int CLK_HALF   = 2,
  parameter int AUTO_START = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 valid,
  output logic [DNA_WIDTH-1:0] dna,
  output logic                 dna_clk,
  output logic                 dna_read,
  output logic                 dna_shift,
  output logic                 dna_din,
  input  logic                 dna_dout
);

  localparam int PW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam int CW = $clog2(DNA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t        state;
  logic [PW-1:0] phase;
  logic [CW-1:0] bit_cnt;
  logic          first;
  logic          tc;
  logic          fall;
  logic          kick;

  assign tc      = (phase == PW'(CLK_HALF - 1));
  assign fall    = tc && dna_clk;
  assign kick    = start || ((AUTO_START != 0) && first);
  assign dna_din = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      bit_cnt   <= '0;
      first     <= 1'b1;
      busy      <= 1'b0;
      valid     <= 1'b0;
      dna       <= '0;
      dna_clk   <= 1'b0;
      dna_read  <= 1'b0;
      dna_shift <= 1'b0;
    end else begin
      first <= 1'b0;
      case (state)
        IDLE: begin
          phase   <= '0;
          dna_clk <= 1'b0;
          if (kick) begin
            state    <= LOAD;
            dna_read <= 1'b1;
            busy     <= 1'b1;
            valid    <= 1'b0;
            bit_cnt  <= '0;
          end
        end
        LOAD, SHIFT: begin
          if (tc) begin
            phase   <= '0;
            dna_clk <= ~dna_clk;
          end else begin
            phase <= phase + PW'(1);
          end
          // DOUT is sampled on the dna_clk fall, half a period after the rise that moved it
          if (fall) begin
            dna     <= {dna[DNA_WIDTH-2:0], dna_dout};
            bit_cnt <= bit_cnt + CW'(1);
            if (state == LOAD) begin
              dna_read  <= 1'b0;
              dna_shift <= 1'b1;
              state     <= SHIFT;
            end else if (bit_cnt == CW'(DNA_WIDTH - 1)) begin
              dna_shift <= 1'b0;
              busy      <= 1'b0;
              valid     <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dna_reader.sv
// Bench for dna_reader: three instances (CLK_HALF=2 manual, CLK_HALF=1 manual, CLK_HALF=2 auto-start),
// each driving a behavioural DNA_PORT, checked every cycle against a timing model plus literal expectations.
module tb_dna_reader;

  localparam int W = 57;
  localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]   rst;
  logic [2:0]   st;
  logic [2:0]   dummy;
  logic [W-1:0] pval [3];
  wire  [2:0]   busy, valid, dclk, drd, dsh, ddin, dout;
  wire  [W-1:0] dna [3];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  dna_reader #(.DNA_WIDTH(W), .CLK_HALF(2), .AUTO_START(0)) u0 (
    .clk(clk), .reset(rst[0]), .start(st[0]), .busy(busy[0]), .valid(valid[0]), .dna(dna[0]),
    .dna_clk(dclk[0]), .dna_read(drd[0]), .dna_shift(dsh[0]), .dna_din(ddin[0]), .dna_dout(dout[0]));
  dna_reader #(.DNA_WIDTH(W), .CLK_HALF(1), .AUTO_START(0)) u1 (
    .clk(clk), .reset(rst[1]), .start(st[1]), .busy(busy[1]), .valid(valid[1]), .dna(dna[1]),
    .dna_clk(dclk[1]), .dna_read(drd[1]), .dna_shift(dsh[1]), .dna_din(ddin[1]), .dna_dout(dout[1]));
  dna_reader #(.DNA_WIDTH(W), .CLK_HALF(2), .AUTO_START(1)) u2 (
    .clk(clk), .reset(rst[2]), .start(st[2]), .busy(busy[2]), .valid(valid[2]), .dna(dna[2]),
    .dna_clk(dclk[2]), .dna_read(drd[2]), .dna_shift(dsh[2]), .dna_din(ddin[2]), .dna_dout(dout[2]));

  // Behavioural DNA_PORT: READ loads on a CLK rise, SHIFT moves DIN in, DOUT is the register MSB.
  for (genvar g = 0; g < 3; g++) begin : pm
    logic [W-1:0] preg;
    int rises_tot = 0;
    int rises_rd  = 0;
    always @(posedge dclk[g]) begin
      if (drd[g]) preg <= pval[g];
      else if (dsh[g]) preg <= {preg[W-2:0], ddin[g]};
      rises_tot <= rises_tot + 1;
      if (drd[g]) rises_rd <= rises_rd + 1;
    end
    assign dout[g] = dummy[g] ? 1'b0 : preg[W-1];
  end

  function automatic int rt(input int i);
    case (i)
      0: rt = pm[0].rises_tot;
      1: rt = pm[1].rises_tot;
      default: rt = pm[2].rises_tot;
    endcase
  endfunction

  function automatic int rr(input int i);
    case (i)
      0: rr = pm[0].rises_rd;
      1: rr = pm[1].rises_rd;
      default: rr = pm[2].rises_rd;
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Model: a read is a window of 2*H*W edges after acceptance; everything follows from t = edges since acceptance.
  int          mt [3];
  bit          mb [3], mv [3], mf [3], mk [3], rs [3], ss [3];
  logic [63:0] mold [3], mpv [3], mhold [3];
  int          hv, nb;
  logic [63:0] ed, act, exv;
  bit          e_clk, e_rd, e_sh;

  initial begin
    for (int i = 0; i < 3; i++) mk[i] = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        rs[i] = rst[i];
        ss[i] = st[i];
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        hv = (i == 1) ? 1 : 2;
        if (rs[i]) begin
          mb[i] = 0; mv[i] = 0; mt[i] = 0; mhold[i] = '0;
          mf[i] = (i == 2); mk[i] = 1;
        end else if (mk[i]) begin
          if (mb[i]) begin
            mt[i]++;
            if (mt[i] == 2 * hv * W) begin
              mb[i] = 0; mv[i] = 1; mhold[i] = mpv[i];
            end
          end else if (ss[i] || mf[i]) begin
            mb[i] = 1; mv[i] = 0; mt[i] = 0;
            mold[i] = mhold[i];
            mpv[i] = dummy[i] ? 64'd0 : {7'd0, pval[i]};
          end
          mf[i] = 0;
        end
        if (mk[i]) begin
          if (mb[i]) begin
            nb = mt[i] / (2 * hv);
            ed = ((mold[i] << nb) | (mpv[i] >> (W - nb))) & MASK;
          end else begin
            ed = mhold[i];
          end
          e_clk = mb[i] && ((mt[i] / hv) % 2 == 1);
          e_rd  = mb[i] && (mt[i] < 2 * hv);
          e_sh  = mb[i] && (mt[i] >= 2 * hv);
          exv = {1'b0, mb[i], mv[i], e_clk, e_rd, e_sh, 1'b0, ed[W-1:0]};
          act = {1'b0, busy[i], valid[i], dclk[i], drd[i], dsh[i], ddin[i], dna[i]};
          check($sformatf("model_inst%0d", i), act, exv);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pulse_start(input int i, output int k);
    st[i] = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    st[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, output int e);
    int n;
    n = 0;
    while (!valid[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (valid[i]) e = cyc;
    else begin
      e = -1;
      checks++;
      failures++;
      $display("FAIL done_timeout inst%0d: valid not seen within %0d cycles", i, budget);
    end
  endtask

  // Auto-start instance: reset released so the first low-reset edge is edge 5.
  initial begin
    int e;
    wait_cyc(4);
    rst[2] = 1'b0;
    @(negedge clk);
    check("auto_read_first_cycle", {62'd0, drd[2], busy[2]}, 64'd3);
    wait_done(2, 400, e);
    check("auto_done_edge", 64'(e), 64'd233);
    check("auto_dna", {7'd0, dna[2]}, 64'h00DEADBEEFCAFE01);
  end

  initial begin
    int k, k2, e, r0, rd0;
    rst = 3'b111; st = 3'b000; dummy = 3'b000;
    pval[0] = 57'h1A5A5A5A5A5A5A5;
    pval[1] = 57'h123456789ABCDEF;
    pval[2] = 57'h0DEADBEEFCAFE01;
    wait_cyc(1);
    check("reset_outputs", {busy[0], valid[0], dclk[0], drd[0], dsh[0], dna[0]}, 64'd0);
    wait_cyc(2);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Basic read with start at edge 10
    wait_cyc(9);
    r0 = rt(0); rd0 = rr(0);
    pulse_start(0, k);
    check("start_edge", 64'(k), 64'd10);
    check("read_busy_after_start", {62'd0, drd[0], busy[0]}, 64'd3);
    wait_done(0, 300, e);
    check("latency_a", 64'(e - k), 64'd228);
    check("dna_a", {7'd0, dna[0]}, 64'h01A5A5A5A5A5A5A5);
    check("rises_a", 64'(rt(0) - r0), 64'd57);
    check("read_rises_a", 64'(rr(0) - rd0), 64'd1);

    // Second read with stray starts while busy
    @(negedge clk);
    r0 = rt(0); rd0 = rr(0);
    pulse_start(0, k2);
    check("valid_drops_b", {63'd0, valid[0]}, 64'd0);
    wait_cyc(k2 + 19);
    pulse_start(0, k);
    wait_cyc(k2 + 99);
    pulse_start(0, k);
    wait_done(0, 300, e);
    check("latency_b", 64'(e - k2), 64'd228);
    check("dna_b", {7'd0, dna[0]}, 64'h01A5A5A5A5A5A5A5);
    check("read_rises_b", 64'(rr(0) - rd0), 64'd1);

    // Reset 100 edges into a read, then a clean read
    @(negedge clk);
    pulse_start(0, k);
    wait_cyc(k + 99);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("abort_outputs", {busy[0], valid[0], dclk[0], drd[0], dsh[0], dna[0]}, 64'd0);
    @(negedge clk);
    pulse_start(0, k);
    wait_done(0, 300, e);
    check("latency_c", 64'(e - k), 64'd228);
    check("dna_c", {7'd0, dna[0]}, 64'h01A5A5A5A5A5A5A5);

    // Dummy primitive after a nonzero result
    @(negedge clk);
    dummy[0] = 1'b1;
    pulse_start(0, k);
    check("valid_drops_d", {63'd0, valid[0]}, 64'd0);
    wait_done(0, 300, e);
    check("latency_d", 64'(e - k), 64'd228);
    check("dna_d", {7'd0, dna[0]}, 64'd0);

    // CLK_HALF = 1
    wait_cyc(cyc + 3);
    r0 = rt(1); rd0 = rr(1);
    pulse_start(1, k);
    @(negedge clk);
    check("h1_clk_rise", {63'd0, dclk[1]}, 64'd1);
    @(negedge clk);
    check("h1_clk_fall", {62'd0, dclk[1], dsh[1]}, 64'd1);
    wait_done(1, 200, e);
    check("latency_e", 64'(e - k), 64'd114);
    check("dna_e", {7'd0, dna[1]}, 64'h0123456789ABCDEF);
    check("rises_e", 64'(rt(1) - r0), 64'd57);
    check("read_rises_e", 64'(rr(1) - rd0), 64'd1);

    wait_cyc(cyc + 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
